// File: rtl/vproc_pkg.sv
// Shared types for the vector FPU write-back path: fflags, register write
// requests and the FPU pipeline control word.
package vproc_pkg;

    localparam int unsigned FFLAGS_W   = 5;
    localparam int unsigned VREG_W_DEF = 128;

    typedef logic [FFLAGS_W-1:0] fpu_fflags_t;

    typedef struct packed {
        logic [4:0]              addr;
        logic [VREG_W_DEF-1:0]   data;
        logic [VREG_W_DEF/8-1:0] be;
    } vreg_wr_req_t;

    typedef struct packed {
        logic op_reduction;
    } fpu_mode_t;

    typedef struct packed {
        fpu_mode_t fpu;
    } op_mode_t;

    typedef struct packed {
        logic       first_cycle;
        logic       last_cycle;
        logic [4:0] res_vaddr;
        op_mode_t   mode;
    } pipe_ctrl_t;

endpackage

// File: rtl/vproc_fpu_wrback_chk.sv
// Protocol checks for the FPU write-back stage: beat grouping rules and
// stability of a stalled register write.
module vproc_fpu_wrback_chk #(
    parameter int unsigned VREG_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              beat_acc_i,
    input  logic              cnt_nz_i,
    input  logic              vaddr_mismatch_i,
    input  logic              reduction_i,
    input  logic              wr_valid_i,
    input  logic              wr_ready_i,
    input  logic [4:0]        wr_addr_i,
    input  logic [VREG_W-1:0] wr_data_i,
    input  logic [VREG_W/8-1:0] wr_be_i
);

    a_vaddr_const: assert property (@(posedge clk_i) disable iff (rst_i)
        (beat_acc_i & cnt_nz_i) |-> ~vaddr_mismatch_i);

    a_red_slot0: assert property (@(posedge clk_i) disable iff (rst_i)
        (beat_acc_i & reduction_i) |-> ~cnt_nz_i);

    a_wr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (wr_valid_i & ~wr_ready_i) |=> (wr_valid_i & $stable(wr_addr_i)
                                        & $stable(wr_data_i) & $stable(wr_be_i)));

endmodule

// File: rtl/vproc_fpu_wrback.sv
// Packs FPU result beats into vector-register write requests and accumulates
// per-instruction floating-point exception flags.
module vproc_fpu_wrback
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W   = 128,
    parameter int unsigned FPU_OP_W = 64,
    parameter type         CTRL_T   = pipe_ctrl_t
) (
    input  logic                  clk_i,
    input  logic                  async_rst_i,
    input  logic                  pipe_in_valid_i,
    output logic                  pipe_in_ready_o,
    input  CTRL_T                 pipe_in_ctrl_i,
    input  logic [FPU_OP_W-1:0]   pipe_in_res_i,
    input  logic [FPU_OP_W/8-1:0] pipe_in_mask_i,
    input  fpu_fflags_t           pipe_in_fflags_i,
    output logic                  vreg_wr_valid_o,
    input  logic                  vreg_wr_ready_i,
    output logic [4:0]            vreg_wr_addr_o,
    output logic [VREG_W-1:0]     vreg_wr_data_o,
    output logic [VREG_W/8-1:0]   vreg_wr_be_o,
    output logic                  fflags_valid_o,
    output fpu_fflags_t           fflags_o
);

    localparam int unsigned PARTS  = VREG_W / FPU_OP_W;
    localparam int unsigned CNT_W  = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int unsigned BEAT_B = FPU_OP_W / 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PARTS - 1);

    logic [CNT_W-1:0]    cnt_r;
    logic [VREG_W-1:0]   fill_data_r;
    logic [VREG_W/8-1:0] fill_be_r;
    logic [4:0]          vaddr_r;
    logic                out_valid_r;
    logic [4:0]          out_addr_r;
    logic [VREG_W-1:0]   out_data_r;
    logic [VREG_W/8-1:0] out_be_r;
    fpu_fflags_t         acc_r;
    logic                fflags_valid_r;
    fpu_fflags_t         fflags_r;

    logic                red_s;
    logic                last_s;
    logic                flush_s;
    logic                ready_s;
    logic                accept_s;
    logic [4:0]          wr_addr_s;
    logic [VREG_W-1:0]   merged_data_s;
    logic [VREG_W/8-1:0] merged_be_s;
    logic                ctrl_unused_s;

    assign red_s         = pipe_in_ctrl_i.mode.fpu.op_reduction;
    assign last_s        = pipe_in_ctrl_i.last_cycle;
    assign flush_s       = (cnt_r == CNT_LAST) | last_s | red_s;
    assign ready_s       = ~flush_s | ~out_valid_r | vreg_wr_ready_i;
    assign accept_s      = pipe_in_valid_i & ready_s;
    assign ctrl_unused_s = pipe_in_ctrl_i.first_cycle;

    // Merge the incoming beat into the fill buffer and pick the destination.
    always_comb begin
        merged_data_s = fill_data_r;
        merged_be_s   = fill_be_r;
        if (red_s) begin
            merged_data_s[FPU_OP_W-1:0] = pipe_in_res_i;
            merged_be_s[BEAT_B-1:0]     = '0;
            merged_be_s[3:0]            = pipe_in_mask_i[3:0];
        end else begin
            merged_data_s[int'(cnt_r)*FPU_OP_W +: FPU_OP_W] = pipe_in_res_i;
            merged_be_s[int'(cnt_r)*BEAT_B +: BEAT_B]       = pipe_in_mask_i;
        end
        if (cnt_r == '0) begin
            wr_addr_s = pipe_in_ctrl_i.res_vaddr;
        end else begin
            wr_addr_s = vaddr_r;
        end
    end

    // Fill buffer and part counter; a flush empties the buffer so unwritten
    // slots of the next group read as zero with be=0.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            cnt_r       <= '0;
            fill_data_r <= '0;
            fill_be_r   <= '0;
            vaddr_r     <= 5'd0;
        end else if (accept_s) begin
            if (cnt_r == '0) begin
                vaddr_r <= pipe_in_ctrl_i.res_vaddr;
            end
            if (flush_s) begin
                cnt_r       <= '0;
                fill_data_r <= '0;
                fill_be_r   <= '0;
            end else begin
                cnt_r       <= cnt_r + CNT_W'(1);
                fill_data_r <= merged_data_s;
                fill_be_r   <= merged_be_s;
            end
        end
    end

    // One-entry output register; drain and refill may happen in the same cycle.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            out_valid_r <= 1'b0;
            out_addr_r  <= 5'd0;
            out_data_r  <= '0;
            out_be_r    <= '0;
        end else if (accept_s & flush_s) begin
            out_valid_r <= 1'b1;
            out_addr_r  <= wr_addr_s;
            out_data_r  <= merged_data_s;
            out_be_r    <= merged_be_s;
        end else if (vreg_wr_ready_i) begin
            out_valid_r <= 1'b0;
        end
    end

    // Per-instruction exception flag accumulation, reported independently of the write.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            acc_r          <= '0;
            fflags_valid_r <= 1'b0;
            fflags_r       <= '0;
        end else if (accept_s & last_s) begin
            acc_r          <= '0;
            fflags_valid_r <= 1'b1;
            fflags_r       <= acc_r | pipe_in_fflags_i;
        end else if (accept_s) begin
            acc_r          <= acc_r | pipe_in_fflags_i;
            fflags_valid_r <= 1'b0;
        end else begin
            fflags_valid_r <= 1'b0;
        end
    end

    assign pipe_in_ready_o = ready_s;
    assign vreg_wr_valid_o = out_valid_r;
    assign vreg_wr_addr_o  = out_addr_r;
    assign vreg_wr_data_o  = out_data_r;
    assign vreg_wr_be_o    = out_be_r;
    assign fflags_valid_o  = fflags_valid_r;
    assign fflags_o        = fflags_r;

`ifndef SYNTHESIS
    vproc_fpu_wrback_chk #(
        .VREG_W (VREG_W)
    ) u_chk (
        .clk_i            (clk_i),
        .rst_i            (async_rst_i),
        .beat_acc_i       (accept_s),
        .cnt_nz_i         (cnt_r != '0),
        .vaddr_mismatch_i (pipe_in_ctrl_i.res_vaddr != vaddr_r),
        .reduction_i      (red_s),
        .wr_valid_i       (out_valid_r),
        .wr_ready_i       (vreg_wr_ready_i),
        .wr_addr_i        (out_addr_r),
        .wr_data_i        (out_data_r),
        .wr_be_i          (out_be_r)
    );
`endif

endmodule
